// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment type, hex glyph table, decode helper, FSM states.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package seg7_pkg;

    // Segment bits: bit0=a .. bit6=g, active-high.
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'h00;

    // Glyph for nibble n lives at SEG7_HEX[n]. The list runs from F (15) down to 0 (0).
    localparam logic [15:0][6:0] SEG7_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       match;   // pattern is one of the 16 hex glyphs
        logic       blank;   // pattern is all segments off
        logic [3:0] nibble;  // decoded value, 0 when there is no match
    } seg7_dec_t;

    typedef enum logic {
        S_TRACK,
        S_HELD
    } seg7_state_t;

    function automatic seg7_dec_t seg7_to_hex(input seg7_t seg);
        seg7_dec_t d;
        d.match  = 1'b0;
        d.blank  = (seg == SEG7_BLANK);
        d.nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG7_HEX[i]) begin
                d.match  = 1'b1;
                d.nibble = 4'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/seg7_stable.sv
// Stability filter: registers the display bus and strobes o_commit once per stable period.
// Latency: o_commit fires STABLE_CYCLES edges after a new value is first sampled.
// Backpressure: none; the bus is free-running and shorter-lived values are dropped.
// Ports: i_clk/i_rst (sync, active-high); i_samp raw bus; o_samp registered bus; o_commit one-cycle strobe.
module seg7_stable
    import seg7_pkg::*;
#(
    parameter int W             = 11,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_samp,
    output logic [W-1:0] o_samp,
    output logic         o_commit
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [W-1:0]  r_samp;
    logic [CW-1:0] r_cnt;
    seg7_state_t   r_state;
    seg7_state_t   w_state_nxt;
    logic          w_change;
    logic          w_at_max;

    assign w_change = (i_samp != r_samp);
    assign w_at_max = (r_cnt == CNT_MAX);
    assign o_samp   = r_samp;

    // If the bus moves on the very edge that commits, stay in S_TRACK so the
    // new value gets its own commit; otherwise S_HELD would never see a change.
    always_comb begin
        w_state_nxt = r_state;
        o_commit    = 1'b0;
        case (r_state)
            S_TRACK: begin
                if (w_at_max) begin
                    o_commit = 1'b1;
                    if (!w_change) begin
                        w_state_nxt = S_HELD;
                    end
                end
            end
            S_HELD: begin
                if (w_change) begin
                    w_state_nxt = S_TRACK;
                end
            end
            default: w_state_nxt = S_TRACK;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_samp  <= '0;
            r_cnt   <= '0;
            r_state <= S_TRACK;
        end else begin
            r_samp  <= i_samp;
            r_state <= w_state_nxt;
            if (w_change) begin
                r_cnt <= CW'(1);
            end else if (!w_at_max) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// Decodes a multiplexed 7-segment bus back into per-digit nibbles with blank/error flags and frame tracking.
// Latency: outputs update STABLE_CYCLES edges after a pattern is first sampled.
// Backpressure: none; the monitor never stalls the display, unstable patterns are simply not captured.
// Ports: clk/rst (sync, active-high); seg_i a..g; dig_en_i one-hot digit enables;
//        digit_o/blank_o/err_o per-digit result; frame_valid_o level; frame_done_o/update_o/scan_err_o pulses.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   dig_en_i,
    output logic [4*NUM_DIGITS-1:0] digit_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic [NUM_DIGITS-1:0]   err_o,
    output logic                    frame_valid_o,
    output logic                    frame_done_o,
    output logic                    update_o,
    output logic                    scan_err_o
);

    localparam int W = NUM_DIGITS + 7;

    logic [W-1:0]            w_samp;
    logic                    w_commit;
    logic [NUM_DIGITS-1:0]   w_dig_en;
    seg7_t                   w_seg;
    seg7_dec_t               w_dec;
    logic                    w_onehot;
    logic                    w_multi;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic                    w_err;
    logic                    w_changed;
    logic [NUM_DIGITS-1:0]   w_seen_nxt;

    logic [4*NUM_DIGITS-1:0] r_digit;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   r_err;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_frame_valid;
    logic                    r_frame_done;
    logic                    r_update;
    logic                    r_scan_err;

    seg7_stable #(
        .W             (W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stable (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_samp   ({dig_en_i, seg_i}),
        .o_samp   (w_samp),
        .o_commit (w_commit)
    );

    assign w_dig_en = w_samp[W-1:7];
    assign w_seg    = w_samp[6:0];
    assign w_dec    = seg7_to_hex(w_seg);

    // x & (x-1) clears the lowest set bit, so it is zero only for a single-bit x.
    assign w_onehot = (w_dig_en != '0) && ((w_dig_en & (w_dig_en - NUM_DIGITS'(1))) == '0);
    assign w_multi  = (w_dig_en != '0) && !w_onehot;

    assign w_nib      = w_dec.match ? w_dec.nibble : 4'h0;
    assign w_blank    = w_dec.blank;
    assign w_err      = !w_dec.match && !w_dec.blank;
    assign w_seen_nxt = r_seen | w_dig_en;

    always_comb begin
        w_changed = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_dig_en[i] && ({r_digit[4*i +: 4], r_blank[i], r_err[i]} != {w_nib, w_blank, w_err})) begin
                w_changed = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit       <= '0;
            r_blank       <= '1;
            r_err         <= '0;
            r_seen        <= '0;
            r_frame_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_update      <= 1'b0;
            r_scan_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_update     <= 1'b0;
            r_scan_err   <= 1'b0;
            if (w_commit) begin
                if (w_multi) begin
                    r_scan_err <= 1'b1;
                end else if (w_onehot) begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (w_dig_en[i]) begin
                            r_digit[4*i +: 4] <= w_nib;
                            r_blank[i]        <= w_blank;
                            r_err[i]          <= w_err;
                        end
                    end
                    r_update <= w_changed;
                    // Completing the frame restarts the seen mask for the next scan.
                    if (w_seen_nxt == '1) begin
                        r_seen        <= '0;
                        r_frame_done  <= 1'b1;
                        r_frame_valid <= 1'b1;
                    end else begin
                        r_seen <= w_seen_nxt;
                    end
                end
            end
        end
    end

    assign digit_o       = r_digit;
    assign blank_o       = r_blank;
    assign err_o         = r_err;
    assign frame_valid_o = r_frame_valid;
    assign frame_done_o  = r_frame_done;
    assign update_o      = r_update;
    assign scan_err_o    = r_scan_err;

endmodule
